// File: rtl/reg_file_if.sv
// reg_file_if: read, write and exception-capture bus between decode/write-back and the register file.
interface reg_file_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH = 32,
    parameter int XCPT_ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] src1_addr;
    logic [ADDR_WIDTH-1:0] src2_addr;
    logic [DATA_WIDTH-1:0] reg1_data;
    logic [DATA_WIDTH-1:0] reg2_data;
    logic writeEn;
    logic [ADDR_WIDTH-1:0] dest_addr;
    logic [DATA_WIDTH-1:0] writeVal;
    logic xcpt_valid;
    logic [PC_WIDTH-1:0] rmPC;
    logic [XCPT_ADDR_WIDTH-1:0] rmAddr;
    logic [PC_WIDTH-1:0] rm0_data;
    logic [XCPT_ADDR_WIDTH-1:0] rm1_data;

    modport master (
        output src1_addr, src2_addr, writeEn, dest_addr, writeVal, xcpt_valid, rmPC, rmAddr,
        input reg1_data, reg2_data, rm0_data, rm1_data
    );

    modport slave (
        input src1_addr, src2_addr, writeEn, dest_addr, writeVal, xcpt_valid, rmPC, rmAddr,
        output reg1_data, reg2_data, rm0_data, rm1_data
    );
endinterface

// File: rtl/reg_file.sv
// reg_file: general registers with two combinational read ports, one write port, and exception PC/address capture.
module reg_file #(
    parameter int NUM_REGS = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int PC_WIDTH = 32,
    parameter int XCPT_ADDR_WIDTH = 32
) (
    input logic clock,
    input logic reset,
    reg_file_if.slave bus
);
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [PC_WIDTH-1:0] rm0;
    logic [XCPT_ADDR_WIDTH-1:0] rm1;
    logic [ADDR_WIDTH-1:0] src1, src2, dest;

    assign src1 = bus.src1_addr;
    assign src2 = bus.src2_addr;
    assign dest = bus.dest_addr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            rm0 <= '0;
            rm1 <= '0;
        end else begin
            if (bus.writeEn) regs[dest] <= bus.writeVal;
            if (bus.xcpt_valid) begin
                rm0 <= bus.rmPC;
                rm1 <= bus.rmAddr;
            end
        end
    end

    assign bus.reg1_data = regs[src1];
    assign bus.reg2_data = regs[src2];
    assign bus.rm0_data = rm0;
    assign bus.rm1_data = rm1;
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed vector table, corner sequences and randomized checks against an array model.
module tb_reg_file;
    logic clock;
    logic reset;
    int tests = 0;
    int fails = 0;
    logic [31:0] m_regs [32];
    logic [31:0] m_rm0, m_rm1;

    reg_file_if bus ();
    reg_file dut (.clock(clock), .reset(reset), .bus(bus));

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic we;
        logic [4:0] dest;
        logic [31:0] wval;
        logic xv;
        logic [31:0] pc;
        logic [31:0] xaddr;
        logic [4:0] s1;
        logic [4:0] s2;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [31:0] exp_rm0;
        logic [31:0] exp_rm1;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.writeEn = 0;
        bus.xcpt_valid = 0;
        bus.dest_addr = 0;
        bus.writeVal = 0;
        bus.rmPC = 0;
        bus.rmAddr = 0;
    endtask

    initial begin
        vecs[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0};
        vecs[1] = '{1, 0, 32'h12345678, 0, 0, 0, 5, 0, 32'hDEADBEEF, 32'h12345678, 0, 0};
        vecs[2] = '{0, 5, 32'h0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
        vecs[3] = '{1, 7, 32'h1, 0, 0, 0, 7, 0, 32'h1, 32'h12345678, 0, 0};
        vecs[4] = '{0, 3, 32'hFFFF, 0, 0, 0, 3, 7, 32'h0, 32'h1, 0, 0};
        vecs[5] = '{1, 9, 32'hAA, 1, 32'h1000, 32'h80000004, 9, 5, 32'hAA, 32'hDEADBEEF, 32'h1000, 32'h80000004};
        vecs[6] = '{0, 9, 32'h55, 0, 32'hFFFF, 32'h1, 9, 0, 32'hAA, 32'h12345678, 32'h1000, 32'h80000004};
        vecs[7] = '{1, 12, 32'h111, 0, 0, 0, 12, 9, 32'h111, 32'hAA, 32'h1000, 32'h80000004};
        vecs[8] = '{1, 12, 32'h222, 0, 0, 0, 12, 12, 32'h222, 32'h222, 32'h1000, 32'h80000004};

        reset = 0;
        idle();
        bus.src1_addr = 0;
        bus.src2_addr = 31;
        #2;
        check("reset_r1", bus.reg1_data, 0);
        check("reset_r2", bus.reg2_data, 0);
        check("reset_rm0", bus.rm0_data, 0);
        check("reset_rm1", bus.rm1_data, 0);
        step();
        step();
        reset = 1;
        step();

        foreach (vecs[k]) begin
            bus.writeEn = vecs[k].we;
            bus.dest_addr = vecs[k].dest;
            bus.writeVal = vecs[k].wval;
            bus.xcpt_valid = vecs[k].xv;
            bus.rmPC = vecs[k].pc;
            bus.rmAddr = vecs[k].xaddr;
            bus.src1_addr = vecs[k].s1;
            bus.src2_addr = vecs[k].s2;
            step();
            idle();
            #1;
            check($sformatf("vec%0d_r1", k), bus.reg1_data, vecs[k].exp1);
            check($sformatf("vec%0d_r2", k), bus.reg2_data, vecs[k].exp2);
            check($sformatf("vec%0d_rm0", k), bus.rm0_data, vecs[k].exp_rm0);
            check($sformatf("vec%0d_rm1", k), bus.rm1_data, vecs[k].exp_rm1);
        end

        bus.writeEn = 1;
        bus.dest_addr = 7;
        bus.writeVal = 32'h2;
        bus.src1_addr = 7;
        #1;
        check("nobypass_before", bus.reg1_data, 32'h1);
        step();
        idle();
        check("nobypass_after", bus.reg1_data, 32'h2);

        #2;
        bus.writeEn = 1;
        bus.dest_addr = 5;
        bus.writeVal = 32'hCAFE;
        bus.xcpt_valid = 1;
        bus.rmPC = 32'h77;
        bus.rmAddr = 32'h88;
        bus.src1_addr = 5;
        bus.src2_addr = 9;
        reset = 0;
        #1;
        check("areset_r1", bus.reg1_data, 0);
        check("areset_r2", bus.reg2_data, 0);
        check("areset_rm0", bus.rm0_data, 0);
        check("areset_rm1", bus.rm1_data, 0);
        for (int a = 0; a < 32; a++) begin
            bus.src1_addr = 5'(a);
            bus.src2_addr = 5'(31 - a);
            #1;
            check("sweep_r1", bus.reg1_data, 0);
            check("sweep_r2", bus.reg2_data, 0);
        end
        check("sweep_rm0", bus.rm0_data, 0);
        check("sweep_rm1", bus.rm1_data, 0);
        idle();
        @(posedge clock);
        #1;
        reset = 1;

        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        m_rm0 = 0;
        m_rm1 = 0;
        bus.writeEn = 1;
        bus.dest_addr = 0;
        bus.writeVal = 32'h5A5A;
        bus.src1_addr = 0;
        step();
        m_regs[0] = 32'h5A5A;
        check("release_first_write", bus.reg1_data, 32'h5A5A);

        for (int n = 0; n < 400; n++) begin
            logic [4:0] d, s1, s2;
            logic [31:0] v, pc, xa;
            logic we, xv;
            we = 1'($urandom_range(0, 1));
            xv = ($urandom_range(0, 3) == 0);
            d = 5'($urandom_range(0, 31));
            s1 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
            s2 = 5'($urandom_range(0, 31));
            v = $urandom;
            pc = $urandom;
            xa = $urandom;
            bus.writeEn = we;
            bus.dest_addr = d;
            bus.writeVal = v;
            bus.xcpt_valid = xv;
            bus.rmPC = pc;
            bus.rmAddr = xa;
            bus.src1_addr = s1;
            bus.src2_addr = s2;
            if ($urandom_range(0, 49) == 0) begin
                #2 reset = 0;
                #1 reset = 1;
                for (int i = 0; i < 32; i++) m_regs[i] = 0;
                m_rm0 = 0;
                m_rm1 = 0;
            end
            #1;
            check("rand_pre_r1", bus.reg1_data, m_regs[s1]);
            check("rand_pre_r2", bus.reg2_data, m_regs[s2]);
            step();
            if (we) m_regs[d] = v;
            if (xv) begin
                m_rm0 = pc;
                m_rm1 = xa;
            end
            check("rand_post_r1", bus.reg1_data, m_regs[s1]);
            check("rand_post_r2", bus.reg2_data, m_regs[s2]);
            check("rand_rm0", bus.rm0_data, m_rm0);
            check("rand_rm1", bus.rm1_data, m_rm1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
